misr_analyzer: RTL and testbench
================================

# misr_analyzer

BIST output response analyzer: compacts a fixed-length stream of circuit-under-test responses into a signature using a multiple-input signature register (MISR), then compares the result against a golden value. It is the receiving end of the LFSR test-pattern generator. The generator drives the CUT, and this block consumes the CUT outputs and produces the pass/fail verdict for the self-test controller.

## Interface
Parameters:
- WIDTH, 3: response and signature width (≥2)
- TAPS, 3'b110: feedback tap mask over signature bits; default realises 1+x^2+x^3
- SEED, 0: signature value loaded at reset and on every Start
- N_PATTERNS, 7: responses compacted per run (≥1; default equals the 3-bit LFSR period)
- GOLDEN, 0: expected final signature

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- Start  in  1  begin a run (accepted in IDLE or DONE)
- Resp  in  WIDTH  CUT response word
- Resp_Valid  in  1  Resp is valid this cycle
- Abort  in  1  present only with MISR_ABORT_EN
- Busy  out  1  run in progress
- Done  out  1  run complete, verdict valid
- Pass  out  1  final signature == GOLDEN (meaningful only while Done=1)
- Signature  out  WIDTH  current MISR contents

## Operation
- FSM states: IDLE, COMPACT, DONE.
- IDLE: Busy=0, Done=0. Start=1 → load sig=SEED, cnt=0, go to COMPACT.
- COMPACT: Busy=1. Each cycle with Resp_Valid=1: fb = XOR-reduce(sig & TAPS); sig ← {sig[WIDTH-2:0], fb} ^ Resp; cnt ← cnt+1.
  - When a valid sample arrives with cnt==N_PATTERNS-1, go to DONE.
  - Resp_Valid=0: sig and cnt hold; no timeout.
  - Start in COMPACT: ignored.
- DONE: Busy=0, Done=1, Pass = (sig==GOLDEN). Outputs hold indefinitely. Start=1 → reseed and return to COMPACT; Done drops on the next cycle.
- Resp_Valid outside COMPACT: ignored; sig unchanged.
- cnt width: $clog2(N_PATTERNS+1). cnt never wraps; a run always terminates at exactly N_PATTERNS samples.
- Reset (any time, including mid-run): state=IDLE, sig=SEED, cnt=0, Busy=0, Done=0, Pass=0. Effect is immediate on RST_N falling edge.

## Timing
- All outputs are registered.
- Signature updates on the edge that samples a valid Resp and is visible the following cycle.
- Busy rises the cycle after Start is sampled.
- Done and Pass rise the cycle after the N_PATTERNS-th valid sample. Minimum run length is N_PATTERNS+1 cycles from Start.
- Pass is registered alongside the DONE transition. It is computed from the post-update signature, never from the pre-update value.

## Configuration
- MISR_ABORT_EN defined: Abort port exists. Abort=1 in COMPACT → IDLE next cycle, sig=SEED, cnt=0, Done=0, Pass=0. Abort takes priority over a coincident valid sample. Abort in IDLE or DONE is ignored.
- Not defined: no Abort port; a run ends only by completion or reset.

## Structure
- Shared package misr_pkg: state enum (IDLE/COMPACT/DONE), default TAPS/SEED/GOLDEN constants, and the default-configuration signature constant used by the bench.
- One sub-module, misr_core: WIDTH/TAPS parameters, inputs load/enable/seed/data, output sig; pure MISR datapath.
- The FSM, counter, and compare logic live in misr_analyzer.

## Test plan
- Reset mid-run: assert RST_N=0 after 3 samples → Busy=0, Done=0, Pass=0, Signature=SEED immediately; a following Start runs a full 7 samples.
- All-zero responses, default params: Start, 7 × Resp=3'b000 with Resp_Valid=1 → Signature=3'b000, Done=1, Pass=1 one cycle after the 7th sample.
- Single-bit fault: Resp=3'b001 on the first sample then 6 × 3'b000 → Signature steps 001,010,101,011,111,110,100; final 3'b100, Done=1, Pass=0.
- Valid gaps: the same stream as the single-bit fault case with Resp_Valid=0 inserted after samples 2 and 5 → identical final 3'b100. Done arrives 2 cycles later than in the gap-free run.
- Restart from DONE, plus ignored Start: Start while in DONE → Done=0 next cycle, Signature=SEED, and a new run completes correctly. Start pulsed mid-COMPACT has no effect.
- MISR_ABORT_EN: Abort after 4 samples, coincident with Resp_Valid → IDLE, Signature=SEED, no Done pulse. Without the macro, the port is absent and the bench compiles with the tie-off removed.

Source files
------------

// File: rtl/misr_pkg.sv
// Shared types and default constants for the MISR response analyzer.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int         DEF_WIDTH      = 3;
  localparam logic [2:0] DEF_TAPS       = 3'b110;
  localparam logic [2:0] DEF_SEED       = 3'b000;
  localparam logic [2:0] DEF_GOLDEN     = 3'b000;
  localparam int         DEF_N_PATTERNS = 7;

  // Default-config signature after a single 3'b001 fault on the first of seven samples
  localparam logic [2:0] DEF_FAULT_SIG  = 3'b100;

endpackage

// File: rtl/misr_analyzer_if.sv
// Handshake/bus bundle of the MISR analyzer; the Abort wire exists only when MISR_ABORT_EN is defined.
interface misr_analyzer_if #(
  parameter int WIDTH = 3
);
  logic             Start;
  logic [WIDTH-1:0] Resp;
  logic             Resp_Valid;
`ifdef MISR_ABORT_EN
  logic             Abort;
`endif
  logic             Busy;
  logic             Done;
  logic             Pass;
  logic [WIDTH-1:0] Signature;

`ifdef MISR_ABORT_EN
  modport master (output Start, Resp, Resp_Valid, Abort,
                  input  Busy, Done, Pass, Signature);
  modport slave  (input  Start, Resp, Resp_Valid, Abort,
                  output Busy, Done, Pass, Signature);
`else
  modport master (output Start, Resp, Resp_Valid,
                  input  Busy, Done, Pass, Signature);
  modport slave  (input  Start, Resp, Resp_Valid,
                  output Busy, Done, Pass, Signature);
`endif

endinterface

// File: rtl/misr_core.sv
// Pure MISR datapath: shift with XOR feedback over TAPS, folding in one data word per enabled cycle.
module misr_core #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110,
  parameter logic [WIDTH-1:0] SEED  = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  logic fb;

  assign fb       = ^(sig & TAPS);
  assign sig_next = {sig[WIDTH-2:0], fb} ^ data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= seed;
    end else if (enable) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/misr_analyzer.sv
// BIST response analyzer: compacts N_PATTERNS responses into a MISR signature and compares to GOLDEN.
// Optional feature macro: MISR_ABORT_EN (adds the Abort input to cancel a run in progress).
module misr_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
  parameter int               N_PATTERNS = DEF_N_PATTERNS,
  parameter logic [WIDTH-1:0] GOLDEN     = DEF_GOLDEN
) (
  input logic           CLK,
  input logic           RST_N,
  misr_analyzer_if.slave bus
);

  localparam int              CW   = $clog2(N_PATTERNS + 1);
  localparam logic [CW-1:0]   LAST = CW'(N_PATTERNS - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic             abort;
  logic             start_ok;
  logic             core_load;
  logic             core_en;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] sig_next;

`ifdef MISR_ABORT_EN
  assign abort = bus.Abort && (state == COMPACT);
`else
  assign abort = 1'b0;
`endif

  assign start_ok  = bus.Start && (state != COMPACT);
  assign core_load = start_ok || abort;
  assign core_en   = (state == COMPACT) && bus.Resp_Valid && !abort;

  misr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (core_load),
    .enable   (core_en),
    .seed     (SEED),
    .data     (bus.Resp),
    .sig      (sig),
    .sig_next (sig_next)
  );

  // Pass is taken from sig_next so the verdict reflects the final sample, not the one before it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            state  <= COMPACT;
            cnt    <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            pass_r <= 1'b0;
          end
        end
        COMPACT: begin
          if (abort) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
          end else if (bus.Resp_Valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              pass_r <= (sig_next == GOLDEN);
            end
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          pass_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Pass      = pass_r;
  assign bus.Signature = sig;

endmodule

// File: tb/tb_misr_analyzer.sv
// Scoreboard bench for misr_analyzer with default parameters; define MISR_ABORT_EN to exercise Abort.
module tb_misr_analyzer;
  import misr_pkg::*;

  typedef struct {
    logic [2:0] sig;
    logic       pass;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   edges;
  logic doneSeen = 1'b0;
  exp_t expQ[$];
  exp_t popped;

  misr_analyzer_if #(.WIDTH(3)) bus ();

  misr_analyzer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every rising Done is matched against the oldest expected verdict
  always @(negedge CLK) begin
    if (bus.Done && !doneSeen) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got Done=1, expected no completion");
      end else begin
        popped = expQ.pop_front();
        checkOutput("done_signature", 32'(bus.Signature), 32'(popped.sig));
        checkOutput("done_pass", 32'(bus.Pass), 32'(popped.pass));
      end
    end
    doneSeen = bus.Done;
  end

  task automatic startRun();
    bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    checkOutput("start_busy", 32'(bus.Busy), 32'd1);
    checkOutput("start_done", 32'(bus.Done), 32'd0);
    checkOutput("start_sig", 32'(bus.Signature), 32'(DEF_SEED));
  endtask

  // Seven samples: 'first' then zeros; optional idle cycle after sample indices gapA/gapB,
  // and a Start pulse coincident with sample startAt (must be ignored)
  task automatic applyStimulus(input logic [2:0] first, input int gapA, input int gapB,
                               input int startAt, input logic [2:0] expSig, input logic expPass,
                               output int nEdges);
    expQ.push_back('{sig: expSig, pass: expPass});
    startRun();
    nEdges = 1;
    for (int i = 0; i < 7; i++) begin
      bus.Resp_Valid = 1'b1;
      bus.Resp       = (i == 0) ? first : 3'b000;
      bus.Start      = (i == startAt);
      if (i == 6) checkOutput("pre_last_done", 32'(bus.Done), 32'd0);
      @(posedge CLK); #1;
      nEdges++;
      bus.Resp_Valid = 1'b0;
      bus.Start      = 1'b0;
      if (i == gapA || i == gapB) begin
        @(posedge CLK); #1;
        nEdges++;
      end
    end
    checkOutput("end_busy", 32'(bus.Busy), 32'd0);
    checkOutput("end_done", 32'(bus.Done), 32'd1);
  endtask

  initial begin
    bus.Start      = 1'b0;
    bus.Resp       = 3'b000;
    bus.Resp_Valid = 1'b0;
`ifdef MISR_ABORT_EN
    bus.Abort      = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset_done", 32'(bus.Done), 32'd0);
    checkOutput("reset_pass", 32'(bus.Pass), 32'd0);
    checkOutput("reset_sig", 32'(bus.Signature), 32'(DEF_SEED));
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Single-bit fault from IDLE: 001,010,101,011,111,110,100
    applyStimulus(3'b001, -1, -1, -1, DEF_FAULT_SIG, 1'b0, edges);
    checkOutput("fault_latency", 32'(edges), 32'd8);

    // Restart from DONE with all-zero responses; startRun confirms reseed from 3'b100
    applyStimulus(3'b000, -1, -1, -1, 3'b000, 1'b1, edges);
    checkOutput("zero_latency", 32'(edges), 32'd8);
    checkOutput("zero_pass", 32'(bus.Pass), 32'd1);

    // DONE holds while valid responses keep arriving
    bus.Resp_Valid = 1'b1;
    bus.Resp       = 3'b111;
    repeat (3) @(posedge CLK);
    #1;
    bus.Resp_Valid = 1'b0;
    checkOutput("hold_done", 32'(bus.Done), 32'd1);
    checkOutput("hold_sig", 32'(bus.Signature), 32'd0);
    checkOutput("hold_pass", 32'(bus.Pass), 32'd1);

    // Gaps after samples 2 and 5, plus an ignored Start mid-run
    applyStimulus(3'b001, 1, 4, 3, DEF_FAULT_SIG, 1'b0, edges);
    checkOutput("gap_latency", 32'(edges), 32'd10);

    // Reset mid-run after three samples
    startRun();
    for (int i = 0; i < 3; i++) begin
      bus.Resp_Valid = 1'b1;
      bus.Resp       = (i == 0) ? 3'b001 : 3'b000;
      @(posedge CLK); #1;
    end
    bus.Resp_Valid = 1'b0;
    checkOutput("midrun_sig", 32'(bus.Signature), 32'h5);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.Busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.Done), 32'd0);
    checkOutput("midrst_pass", 32'(bus.Pass), 32'd0);
    checkOutput("midrst_sig", 32'(bus.Signature), 32'(DEF_SEED));
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(3'b001, -1, -1, -1, DEF_FAULT_SIG, 1'b0, edges);
    checkOutput("postrst_latency", 32'(edges), 32'd8);

`ifdef MISR_ABORT_EN
    // Abort coincident with the fifth valid sample
    startRun();
    for (int i = 0; i < 5; i++) begin
      bus.Resp_Valid = 1'b1;
      bus.Resp       = (i == 0) ? 3'b001 : 3'b000;
      bus.Abort      = (i == 4);
      @(posedge CLK); #1;
    end
    bus.Resp_Valid = 1'b0;
    bus.Abort      = 1'b0;
    checkOutput("abort_busy", 32'(bus.Busy), 32'd0);
    checkOutput("abort_done", 32'(bus.Done), 32'd0);
    checkOutput("abort_sig", 32'(bus.Signature), 32'(DEF_SEED));
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("abort_idle_done", 32'(bus.Done), 32'd0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
